ecp5_pll_phase_stepper: RTL and testbench
=========================================

Name: ecp5_pll_phase_stepper

Overview:
- Drives the dynamic phase-adjust inputs of the ECP5 EHXPLLL: PHASESEL, PHASEDIR and PHASESTEP. The CPU/SDRAM clock generator currently ties these off.
- Accepts a request (output select, direction, step count) over a valid/ready handshake.
- Issues correctly timed PHASESTEP pulses, then waits for PLL re-lock.
- Tracks the accumulated phase offset of each PLL output, so software can sweep the SDRAM capture phase.

Parameters:
- SETUP_CYC, 4: cycles PHASESEL/PHASEDIR are held stable before each pulse (≥1).
- PULSE_CYC, 4: cycles PHASESTEP is held low per step (≥1).
- SETTLE_CYC, 16: gap cycles after each pulse before the next setup (≥1).
- LOCK_TIMEOUT, 65535: maximum cycles to wait for synchronised lock after the last step.
- STEP_W, 8: width of the step-count request field.
- OFS_W, 8: width of each per-output offset counter.

Ports:
- clock  in  1  single clock domain (PLL input reference or a derived system clock).
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request strobe.
- req_ready  out  1  high only in IDLE.
- req_sel  in  2  PLL output selector: 0 = CLKOS, 1 = CLKOS2, 2 = CLKOS3, 3 = CLKOP.
- req_dir  in  1  1 = advance (offset +1 per step), 0 = delay (offset −1 per step).
- req_steps  in  STEP_W  number of phase steps.
- pll_locked  in  1  asynchronous PLL LOCK.
- phasesel  out  2  to EHXPLLL PHASESEL[1:0].
- phasedir  out  1  to EHXPLLL PHASEDIR.
- phasestep  out  1  to EHXPLLL PHASESTEP; idle high, active low.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = lock timeout.
- ofs_rd_sel  in  2  offset read select.
- ofs_rd  out  OFS_W  combinational read of the selected offset counter.

Behaviour:
- Reset values: state IDLE; req_ready=1; phasesel=0; phasedir=0; phasestep=1; busy=0; done=0; err=0; all four offset counters=0; lock synchroniser=0; all counters=0.
- pll_locked passes through a 2-FF synchroniser; only the synchronised value (lock_s) is used.
- Request acceptance: a request is accepted on a cycle where req_valid && req_ready. On that cycle sel, dir and steps are latched, and phasesel/phasedir update on the next edge. req_valid while busy is ignored (not queued).
- IDLE -> SETUP on accept with steps ≠ 0.
- Zero steps: IDLE -> DONE directly. No pulse; done is asserted on the following cycle with err=0.
- SETUP: count SETUP_CYC cycles with phasestep=1, then go to PULSE.
- PULSE: phasestep=0 for exactly PULSE_CYC cycles. On exit, phasestep=1, the remaining-step count decrements, and offset[sel] changes by ±1 modulo 2^OFS_W (wrap both ways, e.g. 255+1=0, 0−1=255). Then go to SETTLE.
- SETTLE: count SETTLE_CYC cycles. If steps remain, go to SETUP (sel/dir unchanged); otherwise go to LOCKWAIT.
- LOCKWAIT: timeout counter starts at 0. If lock_s=1, go to DONE with err=0. If the counter reaches LOCK_TIMEOUT, go to DONE with err=1. If lock_s=1 on the timeout cycle, lock wins.
- DONE: done=1 for one cycle; err holds its value until the next accept; then IDLE. req_ready rises the cycle after done.
- phasesel and phasedir never change while state ∈ {SETUP, PULSE, SETTLE}.
- Lock loss during SETUP/PULSE/SETTLE is not checked; only LOCKWAIT evaluates lock.
- Step pulse period: SETUP_CYC + PULSE_CYC + SETTLE_CYC cycles per step. Total active cycles for N steps = N·(SETUP_CYC + PULSE_CYC + SETTLE_CYC) + lock wait + 1 (DONE).
- reset asserted mid-operation:
  - Next edge: phasestep=1 and state IDLE.
  - Offsets cleared to 0. This matches the PLL, which is reset/reprogrammed alongside.
  - No done pulse is issued.
- ofs_rd is purely combinational from ofs_rd_sel. It reflects an offset update in the cycle after the PULSE exit edge.

Test Plan:
- Reset, then request sel=1, dir=1, steps=3, pll_locked held 1 -> three low pulses on phasestep, each 4 cycles long and 24 cycles apart; phasesel=1 and phasedir=1 stable throughout; done pulses with err=0; ofs_rd(sel=1)=3; total busy = 3·24 + 2 + 1 = 75 cycles.
- Request steps=0 -> no phasestep activity; done high exactly 2 cycles after accept; err=0; offsets unchanged.
- sel=2, dir=0, steps=1 from offset 0 -> ofs_rd(sel=2)=255 (wrap); a further dir=1, steps=2 request gives 1.
- pll_locked held 0, LOCK_TIMEOUT=100, steps=1 -> done with err=1 exactly 100 cycles after LOCKWAIT entry; next accept clears err.
- req_valid held high throughout a 2-step operation with different sel/dir -> second request accepted only after done; the first operation's phasesel/phasedir are unperturbed.
- reset asserted in the 2nd PULSE cycle of a 4-step request -> phasestep=1 next cycle; busy=0; no done; all offsets read 0.

Source files
------------

// File: rtl/ecp5_pll_phase_stepper.sv
// Sequencer for the ECP5 EHXPLLL dynamic phase-adjust pins (PHASESEL/PHASEDIR/PHASESTEP).
// It takes step requests over valid/ready, waits for re-lock, and keeps a phase offset per PLL output.
module ecp5_pll_phase_stepper #(
  parameter int SETUP_CYC    = 4,
  parameter int PULSE_CYC    = 4,
  parameter int SETTLE_CYC   = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int STEP_W       = 8,
  parameter int OFS_W        = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_sel,
  input  logic              req_dir,
  input  logic [STEP_W-1:0] req_steps,
  input  logic              pll_locked,
  output logic [1:0]        phasesel,
  output logic              phasedir,
  output logic              phasestep,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [1:0]        ofs_rd_sel,
  output logic [OFS_W-1:0]  ofs_rd
);

  localparam int M1_C    = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int M2_C    = (M1_C > SETTLE_CYC) ? M1_C : SETTLE_CYC;
  localparam int CNT_MAX = (M2_C > LOCK_TIMEOUT) ? M2_C : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_PULSE, ST_SETTLE, ST_LOCKWAIT, ST_DONE
  } state_t;

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [STEP_W-1:0]   steps_r;
  logic [1:0]          sel_r;
  logic                dir_r;
  logic                phasestep_r, ready_r, busy_r, done_r, err_r, err_pend_r;
  logic                lock_meta_r, lock_s_r;
  logic [OFS_W-1:0]    ofs_r [4];
  logic                accept_s, timeout_s, step_exit_s;
  logic [OFS_W-1:0]    ofs_delta_s;

  assign accept_s    = req_valid && ready_r;
  assign step_exit_s = (state_r == ST_PULSE) && (state_s == ST_SETTLE);
  // Adding all-ones is a modulo-2^OFS_W decrement, so both directions wrap naturally.
  assign ofs_delta_s = dir_r ? {{(OFS_W-1){1'b0}}, 1'b1} : {OFS_W{1'b1}};

  // Next-state logic; LOCKWAIT checks lock before timeout so lock wins on the last cycle.
  always_comb begin
    state_s   = state_r;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (req_steps == {STEP_W{1'b0}}) state_s = ST_DONE;
          else                             state_s = ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == SETUP_LAST) state_s = ST_PULSE;
        else                     state_s = ST_SETUP;
      end
      ST_PULSE: begin
        if (cnt_r == PULSE_LAST) state_s = ST_SETTLE;
        else                     state_s = ST_PULSE;
      end
      ST_SETTLE: begin
        if (cnt_r != SETTLE_LAST)             state_s = ST_SETTLE;
        else if (steps_r != {STEP_W{1'b0}})   state_s = ST_SETUP;
        else                                  state_s = ST_LOCKWAIT;
      end
      ST_LOCKWAIT: begin
        if (lock_s_r) begin
          state_s = ST_DONE;
        end else if (cnt_r == LOCK_LAST) begin
          state_s   = ST_DONE;
          timeout_s = 1'b1;
        end else begin
          state_s = ST_LOCKWAIT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and per-state cycle counter (cleared on every state change).
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (state_s != state_r) cnt_r <= {CNT_W{1'b0}};
      else                    cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Request latch, step bookkeeping, offset counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_r       <= 2'd0;
      dir_r       <= 1'b0;
      steps_r     <= {STEP_W{1'b0}};
      phasestep_r <= 1'b1;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      err_pend_r  <= 1'b0;
      for (int i = 0; i < 4; i++) ofs_r[i] <= {OFS_W{1'b0}};
    end else begin
      if (accept_s) begin
        sel_r      <= req_sel;
        dir_r      <= req_dir;
        steps_r    <= req_steps;
        err_r      <= 1'b0;
        err_pend_r <= 1'b0;
      end else if (step_exit_s) begin
        steps_r       <= steps_r - STEP_W'(1);
        ofs_r[sel_r]  <= ofs_r[sel_r] + ofs_delta_s;
      end else if (state_r == ST_LOCKWAIT) begin
        err_pend_r <= timeout_s;
      end else if (state_r == ST_DONE) begin
        err_r <= err_pend_r;
      end else begin
        steps_r <= steps_r;
      end
      phasestep_r <= (state_s != ST_PULSE);
      done_r      <= (state_r == ST_DONE);
      // Ready only after a full IDLE cycle, so it rises the cycle after done.
      ready_r     <= (state_r == ST_IDLE) && (state_s == ST_IDLE);
      busy_r      <= !((state_r == ST_IDLE) && (state_s == ST_IDLE));
    end
  end

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_meta_r <= 1'b0;
      lock_s_r    <= 1'b0;
    end else begin
      lock_meta_r <= pll_locked;
      lock_s_r    <= lock_meta_r;
    end
  end

  assign req_ready = ready_r;
  assign phasesel  = sel_r;
  assign phasedir  = dir_r;
  assign phasestep = phasestep_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign ofs_rd    = ofs_r[ofs_rd_sel];

endmodule

// File: tb/tb_ecp5_pll_phase_stepper.sv
// Directed bench for ecp5_pll_phase_stepper (LOCK_TIMEOUT shortened to 100).
// Cycle 1 of a run is the cycle right after the request is accepted.
module tb_ecp5_pll_phase_stepper;
  logic       clock = 1'b0;
  logic       reset, req_valid, req_dir, pll_locked;
  logic [1:0] req_sel, ofs_rd_sel;
  logic [7:0] req_steps;
  logic       req_ready, phasedir, phasestep, busy, done, err;
  logic [1:0] phasesel;
  logic [7:0] ofs_rd;

  int vectors = 0;
  int miscompares = 0;

  ecp5_pll_phase_stepper #(
    .SETUP_CYC(4), .PULSE_CYC(4), .SETTLE_CYC(16), .LOCK_TIMEOUT(100), .STEP_W(8), .OFS_W(8)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_dir(req_dir), .req_steps(req_steps), .pll_locked(pll_locked),
    .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep), .busy(busy),
    .done(done), .err(err), .ofs_rd_sel(ofs_rd_sel), .ofs_rd(ofs_rd)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] sel, input logic dir, input logic [7:0] steps);
    req_sel = sel; req_dir = dir; req_steps = steps; req_valid = 1'b1;
  endtask

  task automatic read_ofs(input logic [1:0] sel, output logic [7:0] val);
    ofs_rd_sel = sel;
    #1;
    val = ofs_rd;
  endtask

  // Observes one operation until done (bounded); records timing without judging it.
  task automatic watch(input int max_cyc, input logic [1:0] exp_sel, input logic exp_dir,
                       input bit drop_valid, output int done_at, output int busy_cnt,
                       output int low_cnt, output int falls, output int first_fall,
                       output int last_fall, output bit perturbed, output logic err_seen);
    bit prev_hi = 1'b1;
    done_at = -1; busy_cnt = 0; low_cnt = 0; falls = 0; first_fall = -1; last_fall = -1;
    perturbed = 1'b0; err_seen = 1'bx;
    for (int c = 1; c <= max_cyc; c++) begin
      tick;
      if (c == 1 && drop_valid) req_valid = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      if (phasestep !== 1'b1) begin
        low_cnt++;
        if (prev_hi) begin
          falls++;
          if (first_fall < 0) first_fall = c;
          last_fall = c;
        end
      end
      prev_hi = (phasestep === 1'b1);
      if (busy === 1'b1 && (phasesel !== exp_sel || phasedir !== exp_dir)) perturbed = 1'b1;
      if (done === 1'b1) begin
        done_at = c;
        err_seen = err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [7:0] v;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
    vectors++; if (phasestep !== 1'b1) begin miscompares++; $display("FAIL rst_phasestep: got %b expected 1", phasestep); end
    vectors++; if ({phasesel, phasedir} !== 3'b000) begin miscompares++; $display("FAIL rst_sel_dir: got %b expected 000", {phasesel, phasedir}); end
    vectors++; if ({done, err} !== 2'b00) begin miscompares++; $display("FAIL rst_done_err: got %b expected 00", {done, err}); end
    for (int s = 0; s < 4; s++) begin
      read_ofs(s[1:0], v);
      vectors++; if (v !== 8'd0) begin miscompares++; $display("FAIL rst_ofs%0d: got %0d expected 0", s, v); end
    end
  endtask

  task automatic test_three_steps;
    int d, b, l, f, ff, lf; bit p; logic e; logic [7:0] v;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL t3_ready_pre: got %b expected 1", req_ready); end
    issue(2'd1, 1'b1, 8'd3);
    watch(300, 2'd1, 1'b1, 1'b1, d, b, l, f, ff, lf, p, e);
    vectors++; if (d !== 75) begin miscompares++; $display("FAIL t3_done_at: got %0d expected 75", d); end
    vectors++; if (b !== 75) begin miscompares++; $display("FAIL t3_busy_cycles: got %0d expected 75", b); end
    vectors++; if (f !== 3) begin miscompares++; $display("FAIL t3_pulses: got %0d expected 3", f); end
    vectors++; if (l !== 12) begin miscompares++; $display("FAIL t3_low_cycles: got %0d expected 12", l); end
    vectors++; if (ff !== 5) begin miscompares++; $display("FAIL t3_first_pulse: got %0d expected 5", ff); end
    vectors++; if (lf !== 53) begin miscompares++; $display("FAIL t3_last_pulse: got %0d expected 53", lf); end
    vectors++; if (p !== 1'b0) begin miscompares++; $display("FAIL t3_sel_dir_stable: got %b expected 0", p); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL t3_err: got %b expected 0", e); end
    read_ofs(2'd1, v);
    vectors++; if (v !== 8'd3) begin miscompares++; $display("FAIL t3_ofs1: got %0d expected 3", v); end
    tick;
    vectors++; if ({req_ready, busy, done} !== 3'b100) begin miscompares++; $display("FAIL t3_after_done: got %b expected 100", {req_ready, busy, done}); end
  endtask

  task automatic test_zero_steps;
    int d, b, l, f, ff, lf; bit p; logic e; logic [7:0] v;
    issue(2'd3, 1'b1, 8'd0);
    watch(20, 2'd3, 1'b1, 1'b1, d, b, l, f, ff, lf, p, e);
    vectors++; if (d !== 2) begin miscompares++; $display("FAIL z_done_at: got %0d expected 2", d); end
    vectors++; if (l !== 0) begin miscompares++; $display("FAIL z_low_cycles: got %0d expected 0", l); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL z_err: got %b expected 0", e); end
    read_ofs(2'd3, v);
    vectors++; if (v !== 8'd0) begin miscompares++; $display("FAIL z_ofs3: got %0d expected 0", v); end
    read_ofs(2'd1, v);
    vectors++; if (v !== 8'd3) begin miscompares++; $display("FAIL z_ofs1: got %0d expected 3", v); end
    tick;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL z_ready_after: got %b expected 1", req_ready); end
  endtask

  task automatic test_wrap;
    int d, b, l, f, ff, lf; bit p; logic e; logic [7:0] v;
    issue(2'd2, 1'b0, 8'd1);
    watch(100, 2'd2, 1'b0, 1'b1, d, b, l, f, ff, lf, p, e);
    vectors++; if (d !== 27) begin miscompares++; $display("FAIL w1_done_at: got %0d expected 27", d); end
    read_ofs(2'd2, v);
    vectors++; if (v !== 8'd255) begin miscompares++; $display("FAIL w1_ofs2_wrap: got %0d expected 255", v); end
    tick;
    issue(2'd2, 1'b1, 8'd2);
    watch(100, 2'd2, 1'b1, 1'b1, d, b, l, f, ff, lf, p, e);
    vectors++; if (d !== 51) begin miscompares++; $display("FAIL w2_done_at: got %0d expected 51", d); end
    read_ofs(2'd2, v);
    vectors++; if (v !== 8'd1) begin miscompares++; $display("FAIL w2_ofs2: got %0d expected 1", v); end
    tick;
  endtask

  task automatic test_lock_timeout;
    int d, b, l, f, ff, lf; bit p; logic e; logic [7:0] v;
    pll_locked = 1'b0;
    repeat (3) tick;
    issue(2'd0, 1'b1, 8'd1);
    // LOCKWAIT spans cycles 25..124, DONE state 125, done pulse 126.
    watch(300, 2'd0, 1'b1, 1'b1, d, b, l, f, ff, lf, p, e);
    vectors++; if (d !== 126) begin miscompares++; $display("FAIL to_done_at: got %0d expected 126", d); end
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL to_err: got %b expected 1", e); end
    read_ofs(2'd0, v);
    vectors++; if (v !== 8'd1) begin miscompares++; $display("FAIL to_ofs0: got %0d expected 1", v); end
    tick;
    pll_locked = 1'b1;
    repeat (3) tick;
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL to_err_hold: got %b expected 1", err); end
    issue(2'd0, 1'b0, 8'd0);
    tick;
    req_valid = 1'b0;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL to_err_clear: got %b expected 0", err); end
    tick;
    vectors++; if ({done, err} !== 2'b10) begin miscompares++; $display("FAIL to_zero_done: got %b expected 10", {done, err}); end
    tick;
  endtask

  task automatic test_back_to_back;
    int d, b, l, f, ff, lf; bit p; logic e; logic [7:0] v;
    issue(2'd3, 1'b0, 8'd2);
    tick;
    issue(2'd1, 1'b1, 8'd1);
    vectors++; if ({phasesel, phasedir} !== 3'b110) begin miscompares++; $display("FAIL bb_first_latch: got %b expected 110", {phasesel, phasedir}); end
    watch(200, 2'd3, 1'b0, 1'b0, d, b, l, f, ff, lf, p, e);
    vectors++; if (d !== 50) begin miscompares++; $display("FAIL bb_first_done: got %0d expected 50", d); end
    vectors++; if (p !== 1'b0) begin miscompares++; $display("FAIL bb_first_stable: got %b expected 0", p); end
    vectors++; if (f !== 2) begin miscompares++; $display("FAIL bb_first_pulses: got %0d expected 2", f); end
    tick;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL bb_ready: got %b expected 1", req_ready); end
    watch(100, 2'd1, 1'b1, 1'b1, d, b, l, f, ff, lf, p, e);
    vectors++; if (d !== 27) begin miscompares++; $display("FAIL bb_second_done: got %0d expected 27", d); end
    vectors++; if (p !== 1'b0) begin miscompares++; $display("FAIL bb_second_sel_dir: got %b expected 0", p); end
    read_ofs(2'd3, v);
    vectors++; if (v !== 8'd254) begin miscompares++; $display("FAIL bb_ofs3: got %0d expected 254", v); end
    read_ofs(2'd1, v);
    vectors++; if (v !== 8'd4) begin miscompares++; $display("FAIL bb_ofs1: got %0d expected 4", v); end
    tick;
  endtask

  task automatic test_reset_mid_pulse;
    int done_hits = 0;
    int low_hits = 0;
    logic [7:0] v;
    issue(2'd0, 1'b1, 8'd4);
    tick;
    req_valid = 1'b0;
    repeat (5) tick;
    vectors++; if (phasestep !== 1'b0) begin miscompares++; $display("FAIL mr_in_pulse: got %b expected 0", phasestep); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    vectors++; if (phasestep !== 1'b1) begin miscompares++; $display("FAIL mr_phasestep: got %b expected 1", phasestep); end
    vectors++; if ({busy, done, req_ready} !== 3'b001) begin miscompares++; $display("FAIL mr_busy_done_ready: got %b expected 001", {busy, done, req_ready}); end
    for (int s = 0; s < 4; s++) begin
      read_ofs(s[1:0], v);
      vectors++; if (v !== 8'd0) begin miscompares++; $display("FAIL mr_ofs%0d: got %0d expected 0", s, v); end
    end
    for (int c = 0; c < 40; c++) begin
      tick;
      if (done === 1'b1) done_hits++;
      if (phasestep !== 1'b1) low_hits++;
    end
    vectors++; if (done_hits !== 0) begin miscompares++; $display("FAIL mr_no_done: got %0d expected 0", done_hits); end
    vectors++; if (low_hits !== 0) begin miscompares++; $display("FAIL mr_no_pulse: got %0d expected 0", low_hits); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_sel = 2'd0; req_dir = 1'b0; req_steps = 8'd0;
    pll_locked = 1'b1; ofs_rd_sel = 2'd0;
    repeat (3) tick;
    test_reset;
    reset = 1'b0;
    repeat (4) tick;
    test_three_steps;
    test_zero_steps;
    test_wrap;
    test_lock_timeout;
    test_back_to_back;
    test_reset_mid_pulse;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
